// File: rtl/kmer_pkg.sv
// Shared definitions for the k-mer extraction front end: base encoding,
// size limits and the output beat layout.
package kmer_pkg;

    localparam logic [1:0] BASE_A     = 2'd0;
    localparam logic [1:0] BASE_C     = 2'd1;
    localparam logic [1:0] BASE_G     = 2'd2;
    localparam logic [1:0] BASE_T     = 2'd3;
    localparam int         BASE_N_BIT = 2;

    localparam int K_MAX     = 28;
    localparam int KEY_W     = 64;
    localparam int POS_MAX_W = 64;

    // One output beat; pos is sized for the widest legal counter.
    typedef struct packed {
        logic [KEY_W-1:0]     key;
        logic [POS_MAX_W-1:0] pos;
        logic                 strand;
        logic                 is_null;
        logic                 last;
    } kmer_beat_t;

    // Key mask covering the 2K valid bits of a k-mer.
    function automatic logic [KEY_W-1:0] kmer_mask(input int k);
        return (KEY_W'(1) << (2 * k)) - KEY_W'(1);
    endfunction

endpackage

// File: rtl/kmer_extract_if.sv
// Base-in / k-mer-out stream bundle. The slave side is the extractor.
interface kmer_extract_if import kmer_pkg::*; #(parameter int POS_W = 32) ();

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_base;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [KEY_W-1:0] out_key;
    logic [KEY_W-1:0] out_mask;
    logic [POS_W-1:0] out_pos;
    logic             out_strand;
    logic             out_null;
    logic             out_last;

    modport slave (
        input  in_valid, in_base, in_last, out_ready,
        output in_ready, out_valid, out_key, out_mask, out_pos,
               out_strand, out_null, out_last
    );

    modport master (
        output in_valid, in_base, in_last, out_ready,
        input  in_ready, out_valid, out_key, out_mask, out_pos,
               out_strand, out_null, out_last
    );

endinterface

// File: rtl/kmer_shreg.sv
// Forward / reverse-complement k-mer shift registers with the valid-run
// length. Exposes the post-update state so the emit decision for a base is
// made in the same cycle it is accepted.
// Optional macro KMER_HPC_EN: homopolymer compression (repeat bases skipped).
module kmer_shreg import kmer_pkg::*; #(
    parameter int K = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           acc,      // base accepted this cycle
    input  logic [2:0]     base,
    input  logic           last,     // accepted base ends the read
    output logic [2*K-1:0] fwd_nx,   // state after this base, before end-of-read clear
    output logic [2*K-1:0] rev_nx,
    output logic           full,     // len == K after this base
    output logic           sym,      // fwd == rev after this base
    output logic           upd       // base actually shifted in
);

    localparam int KW = 2 * K;
    localparam int LW = $clog2(K + 1);

    logic [KW-1:0] fwd_q, fwd_d, rev_q, rev_d;
    logic [LW-1:0] len_q, len_d, len_nx;
    logic          is_n, dup;
    logic [1:0]    c;

`ifdef KMER_HPC_EN
    logic [1:0] prev_q, prev_d;
    logic       prev_vld_q, prev_vld_d;

    // Previous non-N base of the read; forgotten on N and at end of read.
    always_comb begin
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        if (acc) begin
            if (is_n || last) begin
                prev_vld_d = 1'b0;
            end else begin
                prev_d     = c;
                prev_vld_d = 1'b1;
            end
        end
    end

    // Previous-base register.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q     <= 2'd0;
            prev_vld_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
        end
    end
`endif

    // Shift in the new base, reset the run on N, then clear at end of read.
    always_comb begin
        is_n = base[BASE_N_BIT];
        c    = base[1:0];
`ifdef KMER_HPC_EN
        dup = prev_vld_q && (prev_q == c);
`else
        dup = 1'b0;
`endif
        upd    = acc && !is_n && !dup;
        fwd_nx = fwd_q;
        rev_nx = rev_q;
        len_nx = len_q;
        if (upd) begin
            fwd_nx = (fwd_q << 2) | KW'(c);
            rev_nx = (rev_q >> 2) | (KW'(~c) << (KW - 2));
            len_nx = (len_q == LW'(K)) ? len_q : len_q + LW'(1);
        end else if (acc && is_n) begin
            len_nx = '0;
        end
        full = (len_nx == LW'(K));
        sym  = (fwd_nx == rev_nx);

        fwd_d = fwd_nx;
        rev_d = rev_nx;
        len_d = len_nx;
        if (acc && last) begin
            fwd_d = '0;
            rev_d = '0;
            len_d = '0;
        end
    end

    // k-mer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_q <= '0;
            rev_q <= '0;
            len_q <= '0;
        end else begin
            fwd_q <= fwd_d;
            rev_q <= rev_d;
            len_q <= len_d;
        end
    end

endmodule

// File: rtl/kmer_extract.sv
// Streaming canonical k-mer extractor feeding hash64. One base per cycle in,
// registered output beat carrying key/mask/position/strand/end-of-read.
// Optional macro KMER_HPC_EN: homopolymer-compressed mode (see kmer_shreg).
module kmer_extract import kmer_pkg::*; #(
    parameter int K     = 15,
    parameter int POS_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    kmer_extract_if.slave  bus
);

    localparam int KW = 2 * K;

    logic [KW-1:0]    fwd_nx, rev_nx;
    logic             full, sym, upd, acc, emit;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             out_valid_q, out_valid_d;
    kmer_beat_t       beat_q, beat_d, beat_nx;

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign acc          = bus.in_valid && bus.in_ready;

    kmer_shreg #(.K(K)) u_shreg (
        .clk    (clk),
        .rst    (rst),
        .acc    (acc),
        .base   (bus.in_base),
        .last   (bus.in_last),
        .fwd_nx (fwd_nx),
        .rev_nx (rev_nx),
        .full   (full),
        .sym    (sym),
        .upd    (upd)
    );

    // Canonical choice, position tracking and output register next state.
    always_comb begin
        emit = upd && full && !sym;

        beat_nx         = '0;
        beat_nx.key     = emit ? ((fwd_nx < rev_nx) ? KEY_W'(fwd_nx) : KEY_W'(rev_nx)) : '0;
        beat_nx.strand  = emit && (fwd_nx > rev_nx);
        beat_nx.is_null = !emit;
        beat_nx.last    = bus.in_last;
        beat_nx.pos     = POS_MAX_W'(pos_q);

        pos_d = pos_q;
        if (acc) pos_d = bus.in_last ? '0 : pos_q + POS_W'(1);

        out_valid_d = out_valid_q;
        beat_d      = beat_q;
        if (acc) begin
            // A base that produces nothing lets the register drain.
            out_valid_d = emit || bus.in_last;
            if (emit || bus.in_last) beat_d = beat_nx;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Position counter and output beat register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q       <= '0;
            out_valid_q <= 1'b0;
            beat_q      <= '0;
        end else begin
            pos_q       <= pos_d;
            out_valid_q <= out_valid_d;
            beat_q      <= beat_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_key    = beat_q.key;
    assign bus.out_mask   = kmer_mask(K);
    assign bus.out_pos    = POS_W'(beat_q.pos);
    assign bus.out_strand = beat_q.strand;
    assign bus.out_null   = beat_q.is_null;
    assign bus.out_last   = beat_q.last;

endmodule

// File: doc/kmer_extract.md
# kmer_extract

- Streaming k-mer front end directly upstream of the hash64 stage.
- Accepts one 2-bit nucleotide per handshake and maintains forward and reverse-complement k-mers.
- Emits the canonical k-mer as a 64-bit `key` together with its `mask`, ready to present to hash64, plus position, strand and read-boundary markers for the downstream minimizer window.

## Interface
Parameters:
- `K`, default 15: k-mer length; legal range 1–28.
- `POS_W`, default 32: position counter width.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: reset. Synchronous, active-high; one clock, reset is synchronous and active-high.
- `in_valid`, input, 1: base present.
- `in_ready`, output, 1: base accepted when `in_valid & in_ready`.
- `in_base`, input, 3: `[2]` = ambiguous (N); `[1:0]` encodes A=0, C=1, G=2, T=3.
- `in_last`, input, 1: this base ends the read.
- `out_valid`, output, 1: output beat present.
- `out_ready`, input, 1: downstream accepts the beat.
- `out_key`, output, 64: canonical k-mer, zero-extended from 2K bits.
- `out_mask`, output, 64: constant `(1<<2K)-1`.
- `out_pos`, output, POS_W: 0-based index, within the read, of the last base of the k-mer.
- `out_strand`, output, 1: 0 = forward chosen, 1 = reverse complement chosen.
- `out_null`, output, 1: end-of-read marker beat; carries no k-mer.
- `out_last`, output, 1: final beat of the read.

## Operation
- State:
  - `fwd`, 2K bits.
  - `rev`, 2K bits.
  - `len`: run of consecutive non-N bases, saturating at K.
  - `pos`, POS_W bits: index of the current base within the read.
- On an accepted base `c` that is not N:
  - `fwd = ((fwd<<2)|c) & mask`
  - `rev = (rev>>2) | ((3^c) << (2K-2))`
  - `len = min(len+1, K)`
- On an accepted N: `len = 0`; `fwd` and `rev` are unchanged.
- `pos` increments on every accepted base, N included. It wraps modulo 2^POS_W with no other effect.
- Emit rule, evaluated on the updated state:
  - No emit if `len < K` or `fwd == rev` (palindromic k-mer).
  - If `fwd < rev`: key = `fwd`, strand 0.
  - If `fwd > rev`: key = `rev`, strand 1.
  - Comparison is unsigned on 2K bits.
- `in_last` handling:
  - The beat for that base carries `out_last=1`.
  - If no k-mer emits on that base, a beat with `out_null=1, out_last=1, out_key=0` is produced instead.
  - State then clears: `len=0`, `pos=0`, `fwd=rev=0`.
  - The next accepted base is index 0 of a new read.
- Every accepted base with `in_last=0` and no emit produces no output beat.
- `rst` mid-read:
  - Drops any pending output beat; no end marker is sent.
  - Clears all state; the next base starts a new read.

## Timing
- Single output register.
  - `in_ready = !out_valid | out_ready`, combinational.
  - Sustains one base per cycle when `out_ready` is held high.
- Latency: a base accepted at edge t produces its beat, if any, at the output from cycle t+1.
- While `out_valid & !out_ready`, all `out_*` signals hold stable and `in_ready = 0`.
- When a beat is accepted in the same cycle a new base is accepted:
  - If the new base emits, the register reloads.
  - If the new base does not emit, `out_valid` falls.
- `in_base` is don't-care when `in_valid = 0`.
- Reset values:
  - `out_valid=0`, `out_key=0`, `out_pos=0`, `out_strand=0`, `out_null=0`, `out_last=0`.
  - `out_mask` is the constant.
  - `in_ready=1` in the first cycle after reset.

## Configuration
- Macro: `KMER_HPC_EN`.
- Defined (homopolymer-compressed mode):
  - An accepted non-N base equal to the previous non-N base of the same read does not shift `fwd`/`rev`, does not change `len`, and emits nothing.
  - `pos` still increments.
  - N and `in_last` clear the previous-base memory.
  - `in_last` on a suppressed base still produces the `out_null` end marker.
- Undefined:
  - Every non-N base shifts.
  - No previous-base register is built.

## Structure
- Package `kmer_pkg`:
  - Base encoding constants (`BASE_A`..`BASE_T`, `BASE_N_BIT`).
  - `K_MAX=28`.
  - `KEY_W=64`.
  - Output beat struct: key, pos, strand, null, last.
- One sub-module, `kmer_shreg`:
  - Holds `fwd`, `rev`, `len` and the optional HPC previous-base register.
  - Exposes `full = (len==K)` and `sym = (fwd==rev)`.
- Top level contains the canonical compare, the position counter and the output register/handshake.

## Test plan
- K=3, read "ACGT", `out_ready=1`:
  - Beat 1: key 0x06, strand 0, pos 2.
  - Beat 2: key 0x06, strand 1, pos 3, `out_last=1`.
- K=3, read "ACNGTA":
  - A single beat: key 0x2C, strand 0, pos 5, last.
  - No beat for any window containing N.
- K=4, read "ACGT" (palindrome) → a single beat with `out_null=1`, `out_last=1`. K=3, read "AC" → a single `out_null` beat.
- Backpressure: K=3, "ACGT" streamed with `out_ready` low for 3 cycles after the first beat → first beat held stable, `in_ready=0` throughout, then beat 2 follows with no loss or duplication.
- Reset mid-read: K=3, feed "AC", pulse `rst`, then feed "GTA" with last → only key 0x2C, strand 0, pos 2, last; no beat from "ACG".
- With `KMER_HPC_EN`, K=3, "AACCGT" with last → key 0x06, strand 0, pos 4; then key 0x06, strand 1, pos 5, last. Without the macro, the first beat is key 0x01, strand 0, pos 2.
